// File: rtl/fofb_setpoint_streamer.sv
`default_nettype none
// ============================================================================
// Module      : fofb_setpoint_streamer
// Description : Streams a snapshot of masked setpoint channels as AXI-Stream
//               beats, one frame per dinToggle level change.
// Revision    : 1.0 - initial release
// ============================================================================
module fofb_setpoint_streamer #(
    parameter int RESULT_COUNT = 32,
    parameter int DIN_WIDTH    = 26,
    parameter int TDATA_WIDTH  = 32,
    parameter int INDEX_WIDTH  = (RESULT_COUNT > 1) ? $clog2(RESULT_COUNT) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              dinToggle,
    input  logic [RESULT_COUNT*DIN_WIDTH-1:0] din,
    input  logic [RESULT_COUNT-1:0]           channelMask,
    input  logic                              overrunClear,
    output logic                              SETPOINT_TVALID,
    output logic                              SETPOINT_TLAST,
    input  logic                              SETPOINT_TREADY,
    output logic [TDATA_WIDTH-1:0]            SETPOINT_TDATA,
    output logic [INDEX_WIDTH-1:0]            SETPOINT_TUSER,
    output logic                              busy,
    output logic [15:0]                       overrunCount
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    localparam logic [RESULT_COUNT-1:0] c_ONE = RESULT_COUNT'(1);

    state_t                            r_state;
    logic                              r_tog;
    logic                              r_tog_d;
    logic [RESULT_COUNT*DIN_WIDTH-1:0] r_din;
    logic [RESULT_COUNT-1:0]           r_pending;
    logic                              r_valid;
    logic                              r_last;
    logic [TDATA_WIDTH-1:0]            r_data;
    logic [INDEX_WIDTH-1:0]            r_user;
    logic [15:0]                       r_ovf;

    logic                              w_event;
    logic                              w_xfer;
    logic                              w_finish;
    logic                              w_accept;
    logic                              w_advance;
    logic                              w_overrun;
    logic [RESULT_COUNT-1:0]           w_src_mask;
    logic [RESULT_COUNT*DIN_WIDTH-1:0] w_src_din;
    logic [RESULT_COUNT-1:0]           w_low;
    logic [RESULT_COUNT-1:0]           w_rest;
    logic [INDEX_WIDTH-1:0]            w_idx;
    logic [DIN_WIDTH-1:0]              w_chan;
    logic [TDATA_WIDTH-1:0]            w_ext;

    assign w_event   = r_tog ^ r_tog_d;
    assign w_xfer    = r_valid & SETPOINT_TREADY;
    assign w_finish  = w_xfer & r_last;
    assign w_accept  = w_event & ((r_state == S_IDLE) | w_finish);
    assign w_advance = w_xfer & ~r_last;
    assign w_overrun = w_event & (r_state == S_SEND) & ~w_finish;

    // A newly accepted frame is encoded straight from the inputs so its first
    // beat appears on the accepting edge; otherwise walk the pending snapshot.
    assign w_src_mask = w_accept ? channelMask : r_pending;
    assign w_src_din  = w_accept ? din : r_din;

    always_comb begin
        w_low  = w_src_mask & (~w_src_mask + c_ONE);
        w_rest = w_src_mask & ~w_low;
        w_idx  = '0;
        w_chan = '0;
        for (int i = 0; i < RESULT_COUNT; i++) begin
            if (w_low[i]) begin
                w_idx  = INDEX_WIDTH'(i);
                w_chan = w_src_din[i*DIN_WIDTH +: DIN_WIDTH];
            end
        end
    end

    generate
        if (TDATA_WIDTH > DIN_WIDTH) begin : g_sext_pad
            assign w_ext = {{(TDATA_WIDTH-DIN_WIDTH){w_chan[DIN_WIDTH-1]}}, w_chan};
        end else begin : g_sext_none
            assign w_ext = w_chan;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tog     <= dinToggle;
            r_tog_d   <= dinToggle;
            r_state   <= S_IDLE;
            r_din     <= '0;
            r_pending <= '0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_data    <= '0;
            r_user    <= '0;
            r_ovf     <= '0;
        end else begin
            r_tog   <= dinToggle;
            r_tog_d <= r_tog;

            if (w_accept) begin
                r_din <= din;
                if (channelMask != '0) begin
                    r_state   <= S_SEND;
                    r_valid   <= 1'b1;
                    r_last    <= (w_rest == '0);
                    r_data    <= w_ext;
                    r_user    <= w_idx;
                    r_pending <= w_rest;
                end else begin
                    r_state   <= S_IDLE;
                    r_valid   <= 1'b0;
                    r_last    <= 1'b0;
                    r_pending <= '0;
                end
            end else if (w_advance) begin
                r_last    <= (w_rest == '0);
                r_data    <= w_ext;
                r_user    <= w_idx;
                r_pending <= w_rest;
            end else if (w_finish) begin
                r_state <= S_IDLE;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end

            // Clear coinciding with an overrun leaves exactly that one overrun counted.
            if (overrunClear) begin
                r_ovf <= w_overrun ? 16'd1 : 16'd0;
            end else if (w_overrun && (r_ovf != 16'hFFFF)) begin
                r_ovf <= r_ovf + 16'd1;
            end
        end
    end

    assign SETPOINT_TVALID = r_valid;
    assign SETPOINT_TLAST  = r_last;
    assign SETPOINT_TDATA  = r_data;
    assign SETPOINT_TUSER  = r_user;
    assign busy            = (r_state == S_SEND);
    assign overrunCount    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fofb_setpoint_streamer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fofb_setpoint_streamer
// Description : Directed self-checking bench for fofb_setpoint_streamer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fofb_setpoint_streamer;

    localparam int RC = 4;
    localparam int DW = 26;
    localparam int TW = 32;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              dinToggle = 1'b0;
    logic [RC*DW-1:0]  din;
    logic [RC-1:0]     channelMask = '0;
    logic              overrunClear = 1'b0;
    logic              tready = 1'b1;
    logic              tvalid;
    logic              tlast;
    logic [TW-1:0]     tdata;
    logic [IW-1:0]     tuser;
    logic              busy;
    logic [15:0]       overrunCount;

    logic [RC*DW-1:0]  c_din;
    logic [TW-1:0]     exp_d [RC];
    int                n_checks = 0;
    int                n_pass = 0;

    fofb_setpoint_streamer #(
        .RESULT_COUNT(RC),
        .DIN_WIDTH   (DW),
        .TDATA_WIDTH (TW)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .dinToggle      (dinToggle),
        .din            (din),
        .channelMask    (channelMask),
        .overrunClear   (overrunClear),
        .SETPOINT_TVALID(tvalid),
        .SETPOINT_TLAST (tlast),
        .SETPOINT_TREADY(tready),
        .SETPOINT_TDATA (tdata),
        .SETPOINT_TUSER (tuser),
        .busy           (busy),
        .overrunCount   (overrunCount)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        for (int n = 0; n < 12 && !tvalid; n++) tick();
        check_eq(tag, 32'(tvalid), 32'd1);
    endtask

    task automatic check_beat(input string tag, input int k, input logic lst);
        check_eq({tag, "_valid"}, 32'(tvalid), 32'd1);
        check_eq({tag, "_user"},  32'(tuser), 32'(k));
        check_eq({tag, "_data"},  tdata, exp_d[k]);
        check_eq({tag, "_last"},  32'(tlast), 32'(lst));
    endtask

    initial begin
        c_din = {26'h3FFFFFF, 26'd3, 26'd2, 26'd1};
        din   = c_din;
        exp_d[0] = 32'd1;
        exp_d[1] = 32'd2;
        exp_d[2] = 32'd3;
        exp_d[3] = 32'hFFFFFFFF;

        // Reset state
        tick(); tick();
        check_eq("rst_valid", 32'(tvalid), 32'd0);
        check_eq("rst_last",  32'(tlast), 32'd0);
        check_eq("rst_data",  tdata, 32'd0);
        check_eq("rst_user",  32'(tuser), 32'd0);
        check_eq("rst_busy",  32'(busy), 32'd0);
        check_eq("rst_ovf",   32'(overrunCount), 32'd0);
        rst = 1'b0;
        tick(); tick();
        check_eq("post_rst_idle", 32'(tvalid), 32'd0);

        // Full mask, back-to-back beats, sign extension
        channelMask = 4'b1111;
        dinToggle = ~dinToggle;
        tick();
        check_eq("lat_reg", 32'(tvalid), 32'd0);
        tick();
        check_eq("busy_send", 32'(busy), 32'd1);
        for (int k = 0; k < 4; k++) begin
            check_beat("full", k, k == 3);
            tick();
        end
        check_eq("full_end_valid", 32'(tvalid), 32'd0);
        check_eq("full_end_busy",  32'(busy), 32'd0);

        // Sparse mask with backpressure
        tready = 1'b0;
        channelMask = 4'b1010;
        dinToggle = ~dinToggle;
        wait_valid("bp_wait");
        for (int c = 0; c < 3; c++) begin
            check_beat("bp_hold", 1, 1'b0);
            tick();
        end
        tready = 1'b1;
        check_beat("bp_first", 1, 1'b0);
        tick();
        check_beat("bp_last", 3, 1'b1);
        tick();
        check_eq("bp_end_valid", 32'(tvalid), 32'd0);

        // Overrun during a frame; din/mask changes must not disturb it
        channelMask = 4'b1111;
        dinToggle = ~dinToggle;
        wait_valid("ovr_wait");
        dinToggle = ~dinToggle;
        din = {26'd7, 26'd7, 26'd7, 26'd7};
        channelMask = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            check_beat("ovr", k, k == 3);
            tick();
        end
        check_eq("ovr_end_valid", 32'(tvalid), 32'd0);
        check_eq("ovr_count", 32'(overrunCount), 32'd1);
        din = c_din;
        channelMask = 4'b1111;

        // Clear coinciding with another overrun
        dinToggle = ~dinToggle;
        wait_valid("clr_wait");
        dinToggle = ~dinToggle;
        tick();
        overrunClear = 1'b1;
        tick();
        overrunClear = 1'b0;
        for (int n = 0; n < 12 && tvalid; n++) tick();
        check_eq("clr_end_valid", 32'(tvalid), 32'd0);
        check_eq("clr_inc_count", 32'(overrunCount), 32'd1);
        overrunClear = 1'b1;
        tick();
        overrunClear = 1'b0;
        check_eq("clr_count", 32'(overrunCount), 32'd0);

        // New frame accepted on the TLAST-transfer cycle
        channelMask = 4'b1010;
        dinToggle = ~dinToggle;
        wait_valid("chain_wait");
        check_beat("chain_a1", 1, 1'b0);
        dinToggle = ~dinToggle;
        channelMask = 4'b1100;
        tick();
        check_beat("chain_a3", 3, 1'b1);
        tick();
        check_beat("chain_b2", 2, 1'b0);
        tick();
        check_beat("chain_b3", 3, 1'b1);
        tick();
        check_eq("chain_end_valid", 32'(tvalid), 32'd0);
        check_eq("chain_ovf", 32'(overrunCount), 32'd0);

        // Empty mask frame
        channelMask = 4'b0000;
        dinToggle = ~dinToggle;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_eq("zmask_valid", 32'(tvalid), 32'd0);
            check_eq("zmask_busy",  32'(busy), 32'd0);
        end

        // Reset mid-frame, toggle held steady through release
        channelMask = 4'b1111;
        dinToggle = ~dinToggle;
        wait_valid("mrst_wait");
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_eq("mrst_valid", 32'(tvalid), 32'd0);
        check_eq("mrst_last",  32'(tlast), 32'd0);
        check_eq("mrst_busy",  32'(busy), 32'd0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_eq("mrst_nostart", 32'(tvalid), 32'd0);
        end
        check_eq("mrst_idle_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
